// File: rtl/tmr_counter_core.sv
// rtl/tmr_counter_core.sv - 8-bit timer counter/compare engine with TMO output (optional TMR_EXT_CLR_EN)
module tmr_counter_core #(
  parameter int                   CNT_WIDTH = 8,
  parameter logic [CNT_WIDTH-1:0] TCOR_RST  = 8'hFF
) (
  input  logic                 i_clk_sys,
  input  logic                 i_rst_n,
  input  logic                 i_cnt_en,
  input  logic [1:0]           i_cclr,
  input  logic                 i_ext_clr,
  input  logic                 i_tcnt_wren,
  input  logic                 i_tcora_wren,
  input  logic                 i_tcorb_wren,
  input  logic [CNT_WIDTH-1:0] i_datain,
  input  logic [3:0]           i_os,
  output logic [CNT_WIDTH-1:0] o_tcnt,
  output logic [CNT_WIDTH-1:0] o_tcora,
  output logic [CNT_WIDTH-1:0] o_tcorb,
  output logic                 o_overflow,
  output logic                 o_cma,
  output logic                 o_cmb,
  output logic                 o_tmo
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = {CNT_WIDTH{1'b1}};

  logic                 ev_a;
  logic                 ev_b;
  logic                 ev_ovf;
  logic                 ext_edge;
  logic                 match_clr;
  logic [CNT_WIDTH-1:0] tcnt_nxt;
  logic [1:0]           act_a;
  logic [1:0]           act_b;
  logic                 tmo_nxt;

  // Compare events use the registered count and the pre-write compare values;
  // a TCNT write cycle suppresses them.
  assign ev_a = i_cnt_en & (o_tcnt == o_tcora) & ~i_tcnt_wren;
  assign ev_b = i_cnt_en & (o_tcnt == o_tcorb) & ~i_tcnt_wren;

`ifdef TMR_EXT_CLR_EN
  logic ext_clr_q;

  // Previous sample of the external clear, for rising-edge detection.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) ext_clr_q <= 1'b0;
    else          ext_clr_q <= i_ext_clr;
  end

  assign ext_edge = (i_cclr == 2'b11) & i_ext_clr & ~ext_clr_q;
`else
  // External clear is not built in; mode 11 behaves as no clear.
  assign ext_edge = i_ext_clr & 1'b0;
`endif

  assign match_clr = ((i_cclr == 2'b01) & ev_a) | ((i_cclr == 2'b10) & ev_b);

  // Next TCNT by priority: bus write, external clear, match clear, increment, hold.
  always_comb begin
    tcnt_nxt = o_tcnt;
    ev_ovf   = 1'b0;
    if (i_tcnt_wren) begin
      tcnt_nxt = i_datain;
    end else if (ext_edge || match_clr) begin
      tcnt_nxt = '0;
    end else if (i_cnt_en) begin
      tcnt_nxt = o_tcnt + CNT_ONE;
      ev_ovf   = (o_tcnt == CNT_ONES);
    end
  end

  // Combine per-channel TMO actions: drive-1 beats drive-0 beats toggle.
  always_comb begin
    act_a   = ev_a ? i_os[1:0] : 2'b00;
    act_b   = ev_b ? i_os[3:2] : 2'b00;
    tmo_nxt = o_tmo;
    if (act_a == 2'b10 || act_b == 2'b10)      tmo_nxt = 1'b1;
    else if (act_a == 2'b01 || act_b == 2'b01) tmo_nxt = 1'b0;
    else if (act_a == 2'b11 || act_b == 2'b11) tmo_nxt = ~o_tmo;
  end

  // Counter, compare registers, event pulses and TMO all register together.
  always_ff @(posedge i_clk_sys) begin
    if (!i_rst_n) begin
      o_tcnt     <= '0;
      o_tcora    <= TCOR_RST;
      o_tcorb    <= TCOR_RST;
      o_overflow <= 1'b0;
      o_cma      <= 1'b0;
      o_cmb      <= 1'b0;
      o_tmo      <= 1'b0;
    end else begin
      o_tcnt     <= tcnt_nxt;
      if (i_tcora_wren) o_tcora <= i_datain;
      if (i_tcorb_wren) o_tcorb <= i_datain;
      o_overflow <= ev_ovf;
      o_cma      <= ev_a;
      o_cmb      <= ev_b;
      o_tmo      <= tmo_nxt;
    end
  end

endmodule
